// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet mux arbiter.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Wrapping increment of a requester index within [0, n).
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NUM_REQ-1.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        off;
  int unsigned        sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    found = 1'b0;
    off   = 32'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    idx = IDX_W'(sum);
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns an N:1 beat mux for whole packets and drives
// a single registered valid/ready output stage.
module rr_mux_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_idx
);

  import rr_mux_arbiter_pkg::*;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              grant_valid_q, grant_valid_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [DATA_W-1:0] beat [NUM_REQ];
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              accept_en;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      beat[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbitration FSM, grant-owner handshake and output stage next-state.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    req_ready     = '0;
    accept_en     = !out_valid_q || out_ready;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_idx_q] = accept_en;
        if (req_valid[grant_idx_q] && accept_en) begin
          out_valid_d = 1'b1;
          out_data_d  = beat[grant_idx_q];
          out_last_d  = req_last[grant_idx_q];
          // Last beat accepted: release the mux and advance fairness pointer.
          if (req_last[grant_idx_q]) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            ptr_d         = IDX_W'(next_idx(32'(grant_idx_q), NUM_REQ));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_out_stable    : assert property (@(posedge clk) disable iff (!rst_n)
                                     (out_valid_q && !out_ready) |=> $stable(out_data_q));
  a_grant_range   : assert property (@(posedge clk) disable iff (!rst_n) 32'(grant_idx_q) < NUM_REQ);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: per-requester packet sources, expected
// beat/grant queues, and a negedge monitor that pops and compares.
module tb_rr_mux_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Packet sources: one beat FIFO per requester, entries are {last, data}.
  logic [8:0]   src_mem [N][16];
  int           wr_p [N];
  int           rd_p [N];
  logic [N-1:0] hold;
  logic [N-1:0] fire;
  bit           rand_mode;
  bit           flush;
  bit           sb_en;
  bit           check_bubble;

  logic [8:0] exp_beats [$];
  int         exp_grants [$];

  always @(negedge clk) fire = req_valid & req_ready;

  always @(posedge clk) begin
    #3;
    for (int i = 0; i < N; i++) begin
      if (fire[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
      if (flush) rd_p[i] = wr_p[i];
      if (rand_mode) begin
        req_valid[i]          = 1'($urandom);
        req_last[i]           = 1'($urandom);
        req_data[i*DW +: DW]  = 8'($urandom);
      end else if (rd_p[i] < wr_p[i] && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_mem[i][rd_p[i]][8];
        req_data[i*DW +: DW]  = src_mem[i][rd_p[i]][7:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  end

  // Monitor: checks every accepted output beat and every new grant.
  logic gv_prev    = 1'b0;
  int   low_run    = 0;
  bit   seen_fall  = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_en && out_valid && out_ready) begin
        if (exp_beats.size() == 0) chk("beat_extra", 32'(exp_beats.size()), 32'd1);
        else chk("out_beat", 32'({out_last, out_data}), 32'(exp_beats.pop_front()));
      end
      if (sb_en && grant_valid && !gv_prev) begin
        if (exp_grants.size() == 0) chk("grant_extra", 32'(exp_grants.size()), 32'd1);
        else chk("grant_idx", 32'(grant_idx), 32'(exp_grants.pop_front()));
        if (check_bubble && seen_fall) chk("bubble_len", 32'(low_run), 32'd1);
        low_run = 0;
      end
      if (!grant_valid) begin
        if (gv_prev) begin
          low_run   = 1;
          seen_fall = 1'b1;
        end else begin
          low_run++;
        end
      end
      gv_prev = grant_valid;
    end else begin
      gv_prev   = 1'b0;
      seen_fall = 1'b0;
      low_run   = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][wr_p[r]] = {l, d};
    wr_p[r]++;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_beats.push_back({l, d});
  endtask

  task automatic wait_out_valid(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    chk(name, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (k < budget && !(exp_beats.size() == 0 && exp_grants.size() == 0 &&
                           !grant_valid && !out_valid)) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(k < budget), 32'd1);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    hold         = '0;
    rand_mode    = 1'b1;
    flush        = 1'b1;
    sb_en        = 1'b0;
    check_bubble = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end

    // Reset held with random requester activity: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", 32'({out_valid, out_last, grant_valid, req_ready, out_data, grant_idx}), 32'd0);
    end
    step();
    rand_mode = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    flush = 1'b0;

    // Asynchronous reset in the middle of a packet clears without a clock edge.
    step();
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    wait_out_valid("t1_out_valid");
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({out_valid, grant_valid, req_ready, out_data}), 32'd0);
    flush = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    flush = 1'b0;
    sb_en = 1'b1;

    // Single requester, first-beat latency and beat ordering.
    step();
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    expect_beat(8'hA1, 1'b0);
    expect_beat(8'hA2, 1'b0);
    expect_beat(8'hA3, 1'b1);
    exp_grants.push_back(1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_valid[1] && k < 10);
    chk("t2_req_seen", 32'(req_valid[1]), 32'd1);
    chk("lat_t", 32'({grant_valid, out_valid}), 32'd0);
    @(negedge clk);
    chk("lat_t1", 32'({grant_valid, grant_idx, out_valid}), 32'({1'b1, 2'd1, 1'b0}));
    @(negedge clk);
    chk("lat_t2", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'hA1}));
    drain("t2_drain", 20);

    // Round-robin fairness with single-beat packets from everyone.
    do_reset();
    check_bubble = 1'b1;
    step();
    push(0, 8'h10, 1'b1);
    push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    expect_beat(8'h10, 1'b1);
    expect_beat(8'h11, 1'b1);
    expect_beat(8'h12, 1'b1);
    expect_beat(8'h13, 1'b1);
    expect_beat(8'h14, 1'b1);
    exp_grants.push_back(0);
    exp_grants.push_back(1);
    exp_grants.push_back(2);
    exp_grants.push_back(3);
    exp_grants.push_back(0);
    drain("t3_drain", 60);
    check_bubble = 1'b0;

    // Back-pressure on req2's two-beat packet.
    step();
    out_ready = 1'b0;
    push(2, 8'hC1, 1'b0);
    push(2, 8'hC2, 1'b1);
    expect_beat(8'hC1, 1'b0);
    expect_beat(8'hC2, 1'b1);
    exp_grants.push_back(2);
    wait_out_valid("t4_out_valid");
    for (int s = 0; s < 3; s++) begin
      if (s != 0) @(negedge clk);
      chk("bp_hold", 32'({out_valid, out_last, out_data, req_ready[2], req_valid[2], grant_valid}),
          32'({1'b1, 1'b0, 8'hC1, 1'b0, 1'b1, 1'b1}));
    end
    step();
    out_ready = 1'b1;
    drain("t4_drain", 20);

    // Owner pauses mid-packet while another requester waits.
    step();
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b0);
    push(0, 8'h53, 1'b1);
    expect_beat(8'h51, 1'b0);
    expect_beat(8'h52, 1'b0);
    expect_beat(8'h53, 1'b1);
    expect_beat(8'hD1, 1'b1);
    exp_grants.push_back(0);
    exp_grants.push_back(3);
    wait_out_valid("t5_out_valid");
    step();
    hold[0] = 1'b1;
    push(3, 8'hD1, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("gap_hold", 32'({grant_valid, grant_idx, req_ready[3], req_valid[3]}),
          32'({1'b1, 2'd0, 1'b0, 1'b1}));
    end
    step();
    hold[0] = 1'b0;
    drain("t5_drain", 30);

    // Pointer wrap after requester 3: requesters 0 and 3 alternate.
    step();
    push(0, 8'hE0, 1'b1);
    push(0, 8'hE2, 1'b1);
    push(3, 8'hE1, 1'b1);
    push(3, 8'hE3, 1'b1);
    expect_beat(8'hE0, 1'b1);
    expect_beat(8'hE1, 1'b1);
    expect_beat(8'hE2, 1'b1);
    expect_beat(8'hE3, 1'b1);
    exp_grants.push_back(0);
    exp_grants.push_back(3);
    exp_grants.push_back(0);
    exp_grants.push_back(3);
    drain("t6_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
